sha256_stream_core: RTL and testbench

Parametrised SHA-256 compression engine for the mining datapath. It accepts pre-padded 512-bit blocks over a valid/ready handshake and chains multi-block messages internally. It can optionally re-hash the final digest (double SHA-256, as used for Bitcoin headers and Merkle nodes) without a second pass through the host. It sits between the block formatter (header/Merkle assembler) and the nonce comparator, and replaces the fixed single-round engine.

---
 rtl/sha256_pkg.sv | 79 +++++++
 rtl/sha256_round.sv | 23 ++
 rtl/sha256_stream_core.sv | 199 +++++++++++++++++++
 tb/tb_sha256_stream_core.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state type and the bitwise round/schedule helpers
// shared by the compression datapath.
package sha256_pkg;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // IV packed H0 in the top word, matching the digest/working-variable layout.
    localparam logic [255:0] IV_FLAT = {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};

    typedef enum logic [2:0] {
        StIdle,
        StRound,
        StFinal,
        StDbl,
        StOut
    } state_e;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Word-wise modulo-2^32 sum of two packed 8-word vectors (feed-forward).
    function automatic logic [255:0] add_words(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        for (int unsigned i = 0; i < 8; i++) begin
            r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round. State vector is {a,b,c,d,e,f,g,h}
// with a in the top word.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] state_in,
    input  logic [31:0]  k,
    input  logic [31:0]  w,
    output logic [255:0] state_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    // Compute T1/T2 and shift the working variables down by one position.
    always_comb begin
        {a, b, c, d, e, f, g, h} = state_in;
        t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
        t2 = big_sigma0(a) + maj(a, b, c);
        state_out = {t1 + t2, a, b, c, d + t1, e, f, g};
    end

endmodule

// File: rtl/sha256_stream_core.sv
// SHA-256 compression engine: accepts pre-padded blocks, chains multi-block
// messages through H, optionally re-hashes the final digest (double SHA-256),
// and presents the result on a valid/ready output.
module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    input  logic         blk_dbl,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest,
    output logic         busy
);

    localparam int unsigned R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds_per_cycle
        $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_e       state_q, state_d;
    logic [255:0] h_q, h_d;
    logic [255:0] wv_q, wv_d;
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    logic [5:0]   rnd_q, rnd_d;
    logic         last_q, last_d;
    logic         dbl_q, dbl_d;
    logic [255:0] digest_q, digest_d;
    logic         dv_q, dv_d;

    logic [31:0]  ext [16 + R];
    logic [31:0]  w_shift [16];
    logic [255:0] rounds_out;
    logic [255:0] h_plus;

    // Extend the 16-word window by R new schedule words, then slide it by R.
    always_comb begin
        for (int unsigned m = 0; m < 16; m++) begin
            ext[m] = w_q[m];
        end
        for (int unsigned j = 0; j < R; j++) begin
            ext[16 + j] = small_sigma1(ext[14 + j]) + ext[9 + j] +
                          small_sigma0(ext[1 + j]) + ext[j];
        end
        for (int unsigned m = 0; m < 16; m++) begin
            w_shift[m] = ext[m + R];
        end
    end

    // Chain of R rounds; stage g consumes schedule word W[rnd+g] = w_q[g].
    for (genvar g = 0; g < R; g++) begin : g_rnd
        logic [255:0] st_in;
        logic [255:0] st_out;
        logic [31:0]  k_val;

        if (g == 0) begin : g_head
            assign st_in = wv_q;
        end else begin : g_link
            assign st_in = g_rnd[g-1].st_out;
        end

        assign k_val = K[rnd_q + 6'(g)];

        sha256_round u_round (
            .state_in  (st_in),
            .k         (k_val),
            .w         (w_q[g]),
            .state_out (st_out)
        );
    end

    assign rounds_out = g_rnd[R-1].st_out;
    assign h_plus     = add_words(h_q, wv_q);

    assign blk_ready    = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign digest_valid = dv_q;
    assign digest       = digest_q;

    // Next-state and datapath load selection for every register.
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        wv_d     = wv_q;
        w_d      = w_q;
        rnd_d    = rnd_q;
        last_d   = last_q;
        dbl_d    = dbl_q;
        digest_d = digest_q;
        dv_d     = dv_q;

        unique case (state_q)
            StIdle: begin
                if (blk_valid) begin
                    for (int unsigned i = 0; i < 16; i++) begin
                        w_d[i] = blk_data[511 - 32*i -: 32];
                    end
                    wv_d   = blk_first ? IV_FLAT : h_q;
                    if (blk_first) begin
                        h_d = IV_FLAT;
                    end
                    last_d  = blk_last;
                    dbl_d   = blk_dbl;
                    rnd_d   = '0;
                    state_d = StRound;
                end
            end
            StRound: begin
                wv_d  = rounds_out;
                w_d   = w_shift;
                rnd_d = rnd_q + 6'(R);
                if (rnd_q == 6'(64 - R)) begin
                    // The first pass of a double hash feeds forward inside DBL,
                    // saving a cycle so the second pass starts one edge earlier.
                    state_d = (last_q && dbl_q) ? StDbl : StFinal;
                end
            end
            StFinal: begin
                h_d = h_plus;
                if (!last_q) begin
                    state_d = StIdle;
                end else begin
                    digest_d = h_plus;
                    dv_d     = 1'b1;
                    state_d  = StOut;
                end
            end
            StDbl: begin
                // Second-pass block: 256-bit digest, padding bit, length 256.
                for (int unsigned i = 0; i < 8; i++) begin
                    w_d[i] = h_plus[255 - 32*i -: 32];
                end
                w_d[8] = 32'h8000_0000;
                for (int unsigned i = 9; i < 15; i++) begin
                    w_d[i] = 32'h0;
                end
                w_d[15] = 32'h0000_0100;
                wv_d    = IV_FLAT;
                h_d     = IV_FLAT;
                dbl_d   = 1'b0;
                rnd_d   = '0;
                state_d = StRound;
            end
            StOut: begin
                if (digest_ready) begin
                    dv_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: chaining value, working variables, schedule, flags, output.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            h_q      <= IV_FLAT;
            wv_q     <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
            rnd_q    <= '0;
            last_q   <= 1'b0;
            dbl_q    <= 1'b0;
            digest_q <= '0;
            dv_q     <= 1'b0;
        end else begin
            h_q      <= h_d;
            wv_q     <= wv_d;
            w_q      <= w_d;
            rnd_q    <= rnd_d;
            last_q   <= last_d;
            dbl_q    <= dbl_d;
            digest_q <= digest_d;
            dv_q     <= dv_d;
        end
    end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core: one DUT per legal ROUNDS_PER_CYCLE, exercised in
// turn with known vectors, latency/handshake checks and random chained messages
// compared against a plain algorithmic SHA-256 model.
module tb_sha256_stream_core;

    localparam logic [31:0] TK [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] TIV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [511:0] ABC   = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] EMPTY = {32'h80000000, 480'd0};
    localparam logic [511:0] B1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B2    = {480'd0, 32'h000001c0};
    localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_DBL = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
    localparam logic [255:0] D_448 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] D_EMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic         CLK = 1'b0;
    logic         reset;
    logic         blk_valid, blk_first, blk_last, blk_dbl, digest_ready;
    logic [511:0] blk_data;
    logic [1:0]   sel;

    logic         rdy_v  [4];
    logic         dv_v   [4];
    logic         busy_v [4];
    logic [255:0] dg_v   [4];
    logic         cur_ready, cur_dv, cur_busy;
    logic [255:0] cur_dg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sha256_stream_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .CLK          (CLK),
            .reset        (reset),
            .blk_valid    (blk_valid && (sel == 2'(g))),
            .blk_ready    (rdy_v[g]),
            .blk_data     (blk_data),
            .blk_first    (blk_first),
            .blk_last     (blk_last),
            .blk_dbl      (blk_dbl),
            .digest_valid (dv_v[g]),
            .digest_ready (digest_ready && (sel == 2'(g))),
            .digest       (dg_v[g]),
            .busy         (busy_v[g])
        );
    end

    assign cur_ready = rdy_v[sel];
    assign cur_dv    = dv_v[sel];
    assign cur_busy  = busy_v[sel];
    assign cur_dg    = dg_v[sel];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (rpc sel %0d): observed %h expected %h", tag, sel, obs, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-256 compression with a full 64-entry message schedule.
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int j = 0; j < 8; j++) v[j] = hin[255 - 32*j -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) +
                 ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[i] + w[i];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) +
                 ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) res[255 - 32*j -: 32] = hin[255 - 32*j -: 32] + v[j];
        return res;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Entered just after a negedge; presents one block and returns #1 after the accept edge.
    task automatic send(input logic [511:0] d, input logic f, input logic l, input logic db);
        int k = 0;
        while (!cur_ready && k < 400) begin
            @(negedge CLK);
            k++;
        end
        if (!cur_ready) chk("ready_timeout", 256'(cur_ready), 256'd1);
        blk_data = d; blk_first = f; blk_last = l; blk_dbl = db; blk_valid = 1'b1;
        @(posedge CLK);
        #1;
        blk_valid = 1'b0;
        blk_data  = rand_block();
        blk_first = 1'($urandom); blk_last = 1'($urandom); blk_dbl = 1'($urandom);
    endtask

    // Edges from the accept edge until digest_valid is seen (sampled at negedge).
    task automatic wait_dv(output int lat);
        int k = 0;
        do begin
            @(posedge CLK); k++; @(negedge CLK);
        end while (!cur_dv && k < 400);
        lat = k;
    endtask

    task automatic wait_ready(output int lat);
        int k = 0;
        do begin
            @(posedge CLK); k++; @(negedge CLK);
        end while (!cur_ready && k < 400);
        lat = k;
    endtask

    task automatic consume();
        digest_ready = 1'b1;
        @(posedge CLK);
        #1 digest_ready = 1'b0;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 256'(cur_ready), 256'd1);
        chk({tag, "_dv"},    256'(cur_dv),    256'd0);
        chk({tag, "_dg"},    cur_dg,          256'd0);
        chk({tag, "_busy"},  256'(cur_busy),  256'd0);
    endtask

    initial begin
        int           n, lat, na, nd;
        int           acc [3];
        logic [255:0] mh;
        logic [511:0] blk;

        reset = 1'b1; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0; blk_dbl = 1'b0;
        digest_ready = 1'b0; blk_data = '0; sel = 2'd0;

        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            n   = 64 >> s;
            do_reset();
            chk_reset_outputs("reset");

            // "abc", single pass
            send(ABC, 1'b1, 1'b1, 1'b0);
            wait_dv(lat);
            chk("abc_latency", 256'(lat), 256'(n + 1));
            chk("abc_digest", cur_dg, D_ABC);
            consume();
            chk("abc_ready_after_out", 256'(cur_ready), 256'd1);

            // "abc", double SHA-256
            send(ABC, 1'b1, 1'b1, 1'b1);
            wait_dv(lat);
            chk("dbl_latency", 256'(lat), 256'(2 * n + 2));
            chk("dbl_digest", cur_dg, D_DBL);
            consume();

            // 448-bit message split over two blocks
            send(B1, 1'b1, 1'b0, 1'b0);
            wait_ready(lat);
            chk("b1_ready_latency", 256'(lat), 256'(n + 1));
            chk("b1_no_digest", 256'(cur_dv), 256'd0);
            send(B2, 1'b0, 1'b1, 1'b0);
            wait_dv(lat);
            chk("448_digest", cur_dg, D_448);
            consume();

            // Empty message, then stall the consumer for 10 cycles
            send(EMPTY, 1'b1, 1'b1, 1'b0);
            wait_dv(lat);
            chk("empty_digest", cur_dg, D_EMP);
            for (int c = 0; c < 10; c++) begin
                @(negedge CLK);
                chk("stall_digest", cur_dg, D_EMP);
                chk("stall_dv", 256'(cur_dv), 256'd1);
                chk("stall_ready", 256'(cur_ready), 256'd0);
            end
            consume();

            // Reset in the middle of ROUND, then chain from IV with first=0
            send(B1, 1'b1, 1'b0, 1'b0);
            repeat (2) @(negedge CLK);
            chk("mid_round_busy", 256'(cur_busy), 256'd1);
            reset = 1'b1;
            #1 chk_reset_outputs("rst_round");
            @(negedge CLK) reset = 1'b0;
            @(negedge CLK);
            send(ABC, 1'b0, 1'b1, 1'b0);
            wait_dv(lat);
            chk("abc_after_reset", cur_dg, D_ABC);

            // Reset while the digest is pending in OUT
            reset = 1'b1;
            #1 chk_reset_outputs("rst_out");
            @(negedge CLK) reset = 1'b0;
            @(negedge CLK);

            // Back-to-back "abc" with valid and digest_ready held high
            blk_data = ABC; blk_first = 1'b1; blk_last = 1'b1; blk_dbl = 1'b0;
            blk_valid = 1'b1; digest_ready = 1'b1;
            na = 0; nd = 0;
            for (int c = 0; c < 4 * (n + 3) + 10; c++) begin
                if (na >= 3 && nd >= 3) break;
                if (blk_valid && cur_ready) begin
                    if (na < 3) acc[na] = c;
                    na++;
                end
                if (cur_dv) begin
                    chk("b2b_digest", cur_dg, D_ABC);
                    nd++;
                end
                @(posedge CLK);
                #1;
                if (na >= 3) blk_valid = 1'b0;
                @(negedge CLK);
            end
            blk_valid = 1'b0; digest_ready = 1'b0;
            chk("b2b_accepts", 256'(na), 256'd3);
            chk("b2b_digests", 256'(nd), 256'd3);
            chk("b2b_spacing0", 256'(acc[1] - acc[0]), 256'(n + 3));
            chk("b2b_spacing1", 256'(acc[2] - acc[1]), 256'(n + 3));
            @(negedge CLK);

            // Random chained messages against the model
            do_reset();
            mh = TIV;
            for (int m = 0; m < ((s == 0) ? 4 : 8); m++) begin
                int   nb;
                logic dbl, f;
                nb  = int'($urandom_range(1, 3));
                dbl = 1'($urandom);
                for (int b = 0; b < nb; b++) begin
                    blk = rand_block();
                    f   = (b == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
                    if (f) mh = TIV;
                    mh = compress(mh, blk);
                    send(blk, f, (b == nb - 1), dbl);
                    if (b != nb - 1) begin
                        wait_ready(lat);
                        chk("rnd_ready_latency", 256'(lat), 256'(n + 1));
                    end
                end
                if (dbl) mh = compress(TIV, {mh, 32'h80000000, 192'd0, 32'h00000100});
                wait_dv(lat);
                chk("rnd_latency", 256'(lat), dbl ? 256'(2 * n + 2) : 256'(n + 1));
                chk("rnd_digest", cur_dg, mh);
                consume();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
